// File: rtl/encoder_42_seq_if.sv
// Bundle of request, acknowledge and code signals between a requester/consumer
// (master) and the 4-to-2 sequential priority encoder (slave).
interface encoder_42_seq_if;
    logic d3;
    logic d2;
    logic d1;
    logic d0;
    logic ack;
    logic w1;
    logic w0;
    logic valid;
    logic multi;

    // Requester/consumer side: drives requests and ack, observes the code.
    modport master (
        output d3, d2, d1, d0, ack,
        input  w1, w0, valid, multi
    );

    // Encoder side: observes requests and ack, presents the code.
    modport slave (
        input  d3, d2, d1, d0, ack,
        output w1, w0, valid, multi
    );
endinterface

// File: rtl/encoder_42_seq.sv
// Sequential 4-to-2 priority encoder with sticky pending requests.
// Requests accumulate in a pending register; when idle, the highest pending
// index is granted and held until acknowledged. Priority is fixed (d3 highest).
module encoder_42_seq (
    input  logic               clk,
    input  logic               reset,
    encoder_42_seq_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  p_reg;
    logic [3:0]  p_next;
    logic [1:0]  code_reg;
    logic [1:0]  code_next;
    logic        valid_reg;
    logic        valid_next;
    logic        multi_reg;
    logic        multi_next;

    logic [3:0]  d_vec;
    logic [3:0]  req_all;
    logic [3:0]  grant_oh;
    logic [1:0]  grant_code;
    logic        req_any;
    logic        req_multi;

    assign d_vec   = {bus.d3, bus.d2, bus.d1, bus.d0};
    // Requests visible this cycle: what is already pending plus what arrives now.
    assign req_all = p_reg | d_vec;
    assign req_any = |req_all;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign req_multi = |(req_all & (req_all - 4'd1));

    // A bit wins only if no higher-indexed bit is requesting.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_prio
            assign grant_oh[gi] = req_all[gi] & ~(|(req_all >> (gi + 1)));
        end
    endgenerate

    assign grant_code = {grant_oh[3] | grant_oh[2], grant_oh[3] | grant_oh[1]};

    // Next-state, pending and output-register update logic.
    always_comb begin
        state_next = state_reg;
        p_next     = req_all;
        code_next  = code_reg;
        valid_next = valid_reg;
        multi_next = multi_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_any) begin
                    code_next  = grant_code;
                    multi_next = req_multi;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    // The served request is retired unless it is being
                    // re-asserted in the very cycle of the acknowledge.
                    p_next[code_reg] = d_vec[code_reg];
                    valid_next = 1'b0;
                    multi_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards every pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            p_reg     <= 4'b0000;
            code_reg  <= 2'b00;
            valid_reg <= 1'b0;
            multi_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            code_reg  <= code_next;
            valid_reg <= valid_next;
            multi_reg <= multi_next;
        end
    end

    assign bus.w1    = code_reg[1];
    assign bus.w0    = code_reg[0];
    assign bus.valid = valid_reg;
    assign bus.multi = multi_reg;

endmodule

// File: tb/tb_encoder_42_seq.sv
// Self-checking bench for encoder_42_seq: a table of per-cycle stimulus with
// expected post-edge outputs, routed through a scoreboard queue, plus a short
// hand-written latency check.
module tb_encoder_42_seq;

    logic clk;
    logic reset;

    encoder_42_seq_if bus_if ();

    encoder_42_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] d;
        logic       ack;
        logic       ev;
        logic [1:0] ew;
        logic       em;
    } vec_t;

    typedef struct packed {
        logic       ev;
        logic [1:0] ew;
        logic       em;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic [3:0] d, input logic ack,
                       input logic ev, input logic [1:0] ew, input logic em);
        vec_t v;
        v.rst = rst; v.d = d; v.ack = ack; v.ev = ev; v.ew = ew; v.em = em;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] d, input logic ack);
        reset     = rst;
        bus_if.d3 = d[3];
        bus_if.d2 = d[2];
        bus_if.d1 = d[1];
        bus_if.d0 = d[0];
        bus_if.ack = ack;
    endtask

    initial begin
        exp_t e;
        exp_t act;
        int   lat;
        bit   seen;

        drive(1'b1, 4'b0000, 1'b0);

        // Reset state.
        add(1, 4'b0000, 0, 0, 2'b00, 0);
        add(1, 4'b0000, 0, 0, 2'b00, 0);
        // Each single request: grant, ack, idle (code retained after ack).
        for (int i = 0; i < 4; i++) begin
            add(0, 4'(1 << i), 0, 1, 2'(i), 0);
            add(0, 4'b0000,    1, 0, 2'(i), 0);
            add(0, 4'b0000,    0, 0, 2'(i), 0);
        end
        // Ack while idle is ignored.
        add(0, 4'b0000, 1, 0, 2'b11, 0);
        add(0, 4'b0000, 1, 0, 2'b11, 0);
        add(0, 4'b0000, 1, 0, 2'b11, 0);
        // d1+d3 together: 11 with multi, then 01 alone.
        add(0, 4'b1010, 0, 1, 2'b11, 1);
        add(0, 4'b0000, 0, 1, 2'b11, 1);
        add(0, 4'b0000, 1, 0, 2'b11, 0);
        add(0, 4'b0000, 0, 1, 2'b01, 0);
        add(0, 4'b0000, 1, 0, 2'b01, 0);
        add(0, 4'b0000, 0, 0, 2'b01, 0);
        // Accumulation of d2 while 01 is held.
        add(0, 4'b0010, 0, 1, 2'b01, 0);
        add(0, 4'b0100, 0, 1, 2'b01, 0);
        add(0, 4'b0100, 0, 1, 2'b01, 0);
        add(0, 4'b0100, 0, 1, 2'b01, 0);
        add(0, 4'b0000, 1, 0, 2'b01, 0);
        add(0, 4'b0000, 0, 1, 2'b10, 0);
        // Ack with simultaneous re-request of d2: re-granted after one idle cycle.
        add(0, 4'b0100, 1, 0, 2'b10, 0);
        add(0, 4'b0000, 0, 1, 2'b10, 0);
        add(0, 4'b0000, 1, 0, 2'b10, 0);
        add(0, 4'b0000, 0, 0, 2'b10, 0);
        // Reset while holding with p=1011 discards everything.
        add(0, 4'b1011, 0, 1, 2'b11, 1);
        add(1, 4'b0000, 0, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 0, 0, 2'b00, 0);
        // Requests during reset are overridden.
        add(1, 4'b1000, 0, 0, 2'b00, 0);
        add(0, 4'b0000, 0, 0, 2'b00, 0);
        // Strict priority: continuous d3 starves d0.
        add(0, 4'b1001, 0, 1, 2'b11, 1);
        for (int i = 0; i < 3; i++) begin
            add(0, 4'b1001, 1, 0, 2'b11, 0);
            add(0, 4'b1001, 0, 1, 2'b11, 1);
        end
        add(0, 4'b0000, 1, 0, 2'b11, 0);
        add(0, 4'b0000, 0, 1, 2'b00, 0);
        add(0, 4'b0000, 1, 0, 2'b00, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].d, vecs[k].ack);
            e.ev = vecs[k].ev; e.ew = vecs[k].ew; e.em = vecs[k].em;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            act.ev = bus_if.valid;
            act.ew = {bus_if.w1, bus_if.w0};
            act.em = bus_if.multi;
            checks++;
            if (act != e) begin
                errors++;
                $display("FAIL vec%0d rst=%b d=%b ack=%b: got valid=%b w=%b multi=%b, want valid=%b w=%b multi=%b",
                         k, vecs[k].rst, vecs[k].d, vecs[k].ack,
                         act.ev, act.ew, act.em, e.ev, e.ew, e.em);
            end else begin
                $display("vec%0d rst=%b d=%b ack=%b -> valid=%b w=%b multi=%b ok",
                         k, vecs[k].rst, vecs[k].d, vecs[k].ack, act.ev, act.ew, act.em);
            end
        end

        // Hand-written latency check: one-cycle d2 pulse from idle must give
        // valid exactly one edge later, bounded by a cycle budget.
        drive(0, 4'b0100, 0);
        lat  = 0;
        seen = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(posedge clk);
            #1;
            drive(0, 4'b0000, 0);
            if (bus_if.valid) begin
                seen = 1;
                lat  = c;
            end
        end
        checks++;
        if (!seen || lat != 1) begin
            errors++;
            $display("FAIL latency: got seen=%0b cycles=%0d, want seen=1 cycles=1", seen, lat);
        end else begin
            $display("latency d2 -> valid = %0d cycle ok", lat);
        end
        checks++;
        if ({bus_if.w1, bus_if.w0} != 2'b10 || bus_if.multi !== 1'b0) begin
            errors++;
            $display("FAIL latency_code: got w=%b multi=%b, want w=10 multi=0",
                     {bus_if.w1, bus_if.w0}, bus_if.multi);
        end else begin
            $display("latency grant w=10 multi=0 ok");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
